i2c_frame_detect: RTL and testbench
===================================

# i2c_frame_detect

Front-end stage of the I2C EEPROM slave. Runs on the system clock and synchronises and deglitches the raw SCL/SDA pins. Detects START, repeated START and STOP, counts bits and deserialises bytes. Produces the `load` window, spanning the 9th SCL clock of the address byte, that the downstream address-compare stage uses to latch its comparison and R/W bit.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop synchroniser depth per pin (min 2).
- `FILT_LEN`, 3: consecutive equal synchronised samples required to change a filtered line (min 1).

Ports:
- `clk` in 1: system clock. One clock only.
- `reset_n` in 1: reset, asynchronous, active-low.
- `scl_in` in 1: raw SCL pin.
- `sda_in` in 1: raw SDA pin.
- `scl_f` out 1: filtered SCL. Reset value 1.
- `sda_f` out 1: filtered SDA. Reset value 1.
- `scl_rise` out 1: 1-cycle pulse on a filtered SCL 0→1 transition.
- `scl_fall` out 1: 1-cycle pulse on a filtered SCL 1→0 transition.
- `start_det` out 1: 1-cycle pulse on START or repeated START.
- `stop_det` out 1: 1-cycle pulse on STOP.
- `load` out 1: level, high during the ACK slot of the first byte after a START.
- `rx_byte` out 8: last complete byte, MSB first on the wire.
- `byte_valid` out 1: 1-cycle pulse when `rx_byte` updates.
- `first_byte` out 1: high while the current byte is the address byte.
- `bit_cnt` out 4: bits received in the current byte, 0..8.
- `busy` out 1: high when the state is not IDLE.

All outputs reset to 0, except `scl_f` and `sda_f`, which reset to 1.

## Operation
- **Synchroniser:** a `SYNC_STAGES`-deep chain per pin. Synchroniser flops reset to 1.
- **Filter:** one counter per line, width `$clog2(FILT_LEN+1)`.
  - The counter increments while the synchronised sample ≠ the filtered value, and clears when they are equal.
  - When the count reaches `FILT_LEN`, the filtered value toggles and the counter clears.
- **Edge and condition pulses:** registered in the same cycle the filtered value changes.
  - `start_det`: `sda_f` falls while `scl_f` is 1 and not changing in that cycle.
  - `stop_det`: `sda_f` rises under the same condition.
  - SCL and SDA changing in the same cycle: the SCL edge pulse is issued; no START/STOP is issued.
- **FSM states:** IDLE, BYTE, ACK.
  - IDLE → BYTE on `start_det`. Sets `bit_cnt`=0 and `first_byte`=1.
  - BYTE, on `scl_rise` with `bit_cnt`<8: shift `sda_f` into the LSB of the internal shift register; `bit_cnt`++.
  - BYTE, on the cycle after the `scl_rise` that makes `bit_cnt`=8: `rx_byte` ← shift register and `byte_valid` pulses once.
  - BYTE with `bit_cnt`=8, on `scl_fall` → ACK. `load` ← `first_byte`.
  - ACK, on `scl_fall` (end of the 9th clock) → BYTE. Sets `bit_cnt`=0, `first_byte`=0, `load`=0.
  - Any state, on `start_det` → BYTE. Sets `bit_cnt`=0, `first_byte`=1, `load`=0. This is a repeated START.
  - Any state, on `stop_det` → IDLE. Clears `bit_cnt`, `first_byte` and `load`.
  - `start_det` and `stop_det` are mutually exclusive by construction.
- **Partial bytes:** a byte aborted by START or STOP never produces `byte_valid`. `rx_byte` keeps its previous value.
- **IDLE:** SCL edges are ignored and `bit_cnt` holds at 0.
- **Reset:** `reset_n` low at any time forces IDLE and all reset values immediately, including mid-byte and mid-ACK.

## Timing
- Pin change to `scl_f`/`sda_f` change: `SYNC_STAGES` + `FILT_LEN` clk edges. That is 5 with defaults, assuming the pin is stable.
- Pulses whose width is ≤ `FILT_LEN` − 1 synchronised samples are rejected.
- `load` rises on the clk after the 8th-bit `scl_fall` pulse. It falls on the clk after the 9th-bit `scl_fall` pulse.
  - It is therefore stable across the entire 9th SCL high phase.
  - The downstream stage samples it on the SCL rising edge.
- `byte_valid` follows the 8th `scl_rise` pulse by exactly 1 clk.
- `rx_byte` is stable from `byte_valid` until the next `byte_valid`.
- Minimum SCL high/low time for correct detection: `FILT_LEN` + 2 clk periods.

## Test plan
- **Reset:** hold `reset_n`=0 with pins at 1, then release. Required: `scl_f`=`sda_f`=1, all other outputs 0, `busy`=0.
- **Address byte:** START, then 0xA1, then ACK clock. Required:
  - `byte_valid` exactly once, with `rx_byte`=0xA1 and `first_byte`=1.
  - `load` high from the clk after the 8th `scl_fall` to the clk after the 9th `scl_fall`.
  - `bit_cnt` 8→0.
- **Glitch rejection:** with `FILT_LEN`=3, drive a 2-clk low pulse on `scl_in` mid-byte. Required: no `scl_fall`/`scl_rise`, `bit_cnt` unchanged.
- **Repeated START:** START, 0xA0, ACK, 3 data bits, then START. Required:
  - `start_det` pulse, `bit_cnt`=0, `first_byte`=1.
  - No `byte_valid` for the partial byte; `rx_byte` remains 0xA0.
- **STOP:** STOP after 5 bits. Required: `stop_det` pulse, `busy`=0, `load`=0, no `byte_valid`. Subsequent SCL toggles leave `bit_cnt`=0.
- **Reset mid-ACK:** assert `reset_n`=0 while `load`=1. Required: `load`=0 asynchronously and the FSM is in IDLE on release.

Source files
------------

// File: rtl/i2c_frame_detect.sv
// i2c_frame_detect
//   Front end of the I2C EEPROM slave. Synchronises and deglitches the raw
//   SCL/SDA pins on the system clock, detects START / repeated START / STOP,
//   counts bits and deserialises bytes. `load` is a level that covers the
//   ACK clock of the address byte so the address-compare stage can latch.
//
// Ports
//   clk, reset_n          system clock, async active-low reset
//   scl_in, sda_in        raw I2C pins
//   scl_f, sda_f          filtered lines (reset 1)
//   scl_rise, scl_fall    1-cycle pulses on filtered SCL edges
//   start_det, stop_det   1-cycle pulses on (repeated) START / STOP
//   load                  high during the ACK slot of the first byte
//   rx_byte, byte_valid   last complete byte and its update strobe
//   first_byte            current byte is the address byte
//   bit_cnt               bits received in current byte (0..8)
//   busy                  FSM not in IDLE
module i2c_frame_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       load,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       first_byte,
    output logic [3:0] bit_cnt,
    output logic       busy
);
    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_BYTE, S_ACK} state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic [CW-1:0]          r_scl_cnt, r_sda_cnt;
    logic                   r_scl_f, r_sda_f;
    logic                   r_scl_rise, r_scl_fall, r_start, r_stop;
    logic                   w_scl_s, w_sda_s, w_scl_tog, w_sda_tog;
    state_t                 r_state, w_next;
    logic [7:0]             r_sr, r_rx;
    logic [3:0]             r_bit_cnt;
    logic                   r_bv, r_first, r_load;

    // Synchronisers idle high so reset does not look like a START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

    // Toggle on the FILT_LEN-th consecutive differing sample.
    assign w_scl_tog = (w_scl_s != r_scl_f) && (r_scl_cnt == CW'(FILT_LEN - 1));
    assign w_sda_tog = (w_sda_s != r_sda_f) && (r_sda_cnt == CW'(FILT_LEN - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_cnt  <= (w_scl_s == r_scl_f || w_scl_tog) ? '0 : r_scl_cnt + CW'(1);
            r_sda_cnt  <= (w_sda_s == r_sda_f || w_sda_tog) ? '0 : r_sda_cnt + CW'(1);
            r_scl_f    <= r_scl_f ^ w_scl_tog;
            r_sda_f    <= r_sda_f ^ w_sda_tog;
            r_scl_rise <= w_scl_tog & ~r_scl_f;
            r_scl_fall <= w_scl_tog &  r_scl_f;
            // SDA moving in the same cycle as SCL is a data edge, not a condition.
            r_start    <= w_sda_tog &  r_sda_f & r_scl_f & ~w_scl_tog;
            r_stop     <= w_sda_tog & ~r_sda_f & r_scl_f & ~w_scl_tog;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state
    always_comb begin
        w_next = r_state;
        if (r_stop)       w_next = S_IDLE;
        else if (r_start) w_next = S_BYTE;
        else begin
            case (r_state)
                S_BYTE:  if (r_scl_fall && r_bit_cnt == 4'd8) w_next = S_ACK;
                S_ACK:   if (r_scl_fall) w_next = S_BYTE;
                default: w_next = r_state;
            endcase
        end
    end

    // Datapath tied to the FSM transitions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr      <= '0;
            r_rx      <= '0;
            r_bit_cnt <= '0;
            r_bv      <= 1'b0;
            r_first   <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            r_bv <= 1'b0;
            if (r_stop) begin
                r_bit_cnt <= '0;
                r_first   <= 1'b0;
                r_load    <= 1'b0;
            end else if (r_start) begin
                r_bit_cnt <= '0;
                r_first   <= 1'b1;
                r_load    <= 1'b0;
            end else begin
                case (r_state)
                    S_BYTE: begin
                        if (r_scl_rise && r_bit_cnt < 4'd8) begin
                            r_sr      <= {r_sr[6:0], r_sda_f};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            // Completing bit: publish the byte in the same update.
                            if (r_bit_cnt == 4'd7) begin
                                r_rx <= {r_sr[6:0], r_sda_f};
                                r_bv <= 1'b1;
                            end
                        end
                        if (r_scl_fall && r_bit_cnt == 4'd8) r_load <= r_first;
                    end
                    S_ACK: begin
                        if (r_scl_fall) begin
                            r_bit_cnt <= '0;
                            r_first   <= 1'b0;
                            r_load    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    assign scl_f      = r_scl_f;
    assign sda_f      = r_sda_f;
    assign scl_rise   = r_scl_rise;
    assign scl_fall   = r_scl_fall;
    assign start_det  = r_start;
    assign stop_det   = r_stop;
    assign load       = r_load;
    assign rx_byte    = r_rx;
    assign byte_valid = r_bv;
    assign first_byte = r_first;
    assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_i2c_frame_detect.sv
// Testbench for i2c_frame_detect with default parameters.
module tb_i2c_frame_detect;
    logic       clk = 1'b0;
    logic       reset_n, scl_in, sda_in;
    logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, load;
    logic [7:0] rx_byte;
    logic       byte_valid, first_byte, busy;
    logic [3:0] bit_cnt;

    i2c_frame_detect #(.SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in),
        .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det), .load(load),
        .rx_byte(rx_byte), .byte_valid(byte_valid), .first_byte(first_byte),
        .bit_cnt(bit_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Event log sampled on the falling edge
    int         cyc = 0;
    int         n_bv = 0, n_start = 0, n_stop = 0, n_rise = 0, n_fall = 0;
    int         rise7_c = -10, bv_lat_bad = 0;
    logic [7:0] bv_rx[$];
    logic       bv_first[$];
    int         c8[$];
    int         ld_rise[$], ld_fall[$];
    logic       prev_load = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (scl_rise === 1'b1) begin
            n_rise++;
            if (bit_cnt == 4'd7) rise7_c = cyc;
        end
        if (scl_fall === 1'b1) begin
            n_fall++;
            if (bit_cnt == 4'd8) c8.push_back(cyc);
        end
        if (start_det === 1'b1) n_start++;
        if (stop_det === 1'b1) n_stop++;
        if (byte_valid === 1'b1) begin
            n_bv++;
            bv_rx.push_back(rx_byte);
            bv_first.push_back(first_byte);
            if (cyc != rise7_c + 1) bv_lat_bad++;
        end
        if (load === 1'b1 && !prev_load) ld_rise.push_back(cyc);
        if (load === 1'b0 && prev_load) ld_fall.push_back(cyc);
        prev_load = (load === 1'b1);
    end

    task automatic clr_logs();
        bv_rx.delete(); bv_first.delete(); c8.delete();
        ld_rise.delete(); ld_fall.delete();
        n_bv = 0; bv_lat_bad = 0;
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bus-level stimulus; SCL half periods well above the detection minimum.
    task automatic send_bit(input logic b);
        sda_in = b; wclk(6);
        scl_in = 1'b1; wclk(10);
        scl_in = 1'b0; wclk(8);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic start_cond();   // from idle bus (SCL=SDA=1)
        sda_in = 1'b0; wclk(10);
        scl_in = 1'b0; wclk(8);
    endtask

    task automatic rstart_cond();  // from SCL low
        sda_in = 1'b1; wclk(6);
        scl_in = 1'b1; wclk(10);
        sda_in = 1'b0; wclk(10);
        scl_in = 1'b0; wclk(8);
    endtask

    task automatic stop_cond();    // from SCL low
        sda_in = 1'b0; wclk(6);
        scl_in = 1'b1; wclk(10);
        sda_in = 1'b1; wclk(10);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         exp_bv;
        logic [7:0] exp_rx0;
        logic [7:0] exp_rx1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int s0, r0, f0;
        logic [3:0] bc0;

        vecs[0] = '{addr: 8'hA1, data: 8'h3C, exp_bv: 2, exp_rx0: 8'hA1, exp_rx1: 8'h3C};
        vecs[1] = '{addr: 8'h00, data: 8'hFF, exp_bv: 2, exp_rx0: 8'h00, exp_rx1: 8'hFF};
        vecs[2] = '{addr: 8'hFF, data: 8'h00, exp_bv: 2, exp_rx0: 8'hFF, exp_rx1: 8'h00};
        vecs[3] = '{addr: 8'h5A, data: 8'hA5, exp_bv: 2, exp_rx0: 8'h5A, exp_rx1: 8'hA5};

        // Reset
        reset_n = 1'b0; scl_in = 1'b1; sda_in = 1'b1;
        wclk(3);
        chk("rst_scl_f", scl_f, 1); chk("rst_sda_f", sda_f, 1);
        chk("rst_rise", scl_rise, 0); chk("rst_fall", scl_fall, 0);
        chk("rst_start", start_det, 0); chk("rst_stop", stop_det, 0);
        chk("rst_load", load, 0); chk("rst_rx", rx_byte, 0);
        chk("rst_bv", byte_valid, 0); chk("rst_first", first_byte, 0);
        chk("rst_bitcnt", bit_cnt, 0); chk("rst_busy", busy, 0);
        reset_n = 1'b1; wclk(8);
        chk("post_rst_busy", busy, 0); chk("post_rst_scl_f", scl_f, 1);

        // Address + data frames
        for (int v = 0; v < 4; v++) begin
            clr_logs();
            s0 = n_start;
            start_cond();
            chk("vec_start", n_start - s0, 1);
            chk("vec_first_after_start", first_byte, 1);
            send_byte(vecs[v].addr);
            chk("vec_bitcnt8", bit_cnt, 8);
            chk("vec_load_ack", load, 1);
            send_bit(1'b0);
            chk("vec_bitcnt0", bit_cnt, 0);
            chk("vec_load_off", load, 0);
            chk("vec_first_off", first_byte, 0);
            send_byte(vecs[v].data);
            send_bit(1'b1);
            stop_cond();
            chk("vec_busy", busy, 0);
            chk("vec_bv_n", n_bv, vecs[v].exp_bv);
            chk("vec_bv_lat", bv_lat_bad, 0);
            chk("vec_rx_last", rx_byte, vecs[v].exp_rx1);
            if (bv_rx.size() == 2) begin
                chk("vec_rx0", bv_rx[0], vecs[v].exp_rx0);
                chk("vec_first0", bv_first[0], 1);
                chk("vec_rx1", bv_rx[1], vecs[v].exp_rx1);
                chk("vec_first1", bv_first[1], 0);
            end
            chk("vec_load_rise_n", ld_rise.size(), 1);
            chk("vec_load_fall_n", ld_fall.size(), 1);
            chk("vec_c8_n", c8.size(), 4);
            if (c8.size() >= 2 && ld_rise.size() >= 1 && ld_fall.size() >= 1) begin
                chk("vec_load_rise_t", ld_rise[0], c8[0] + 1);
                chk("vec_load_fall_t", ld_fall[0], c8[1] + 1);
            end
        end

        // Glitch on SCL high mid-byte
        clr_logs();
        start_cond();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        sda_in = 1'b1; wclk(6); scl_in = 1'b1; wclk(10);
        chk("gl_bitcnt_pre", bit_cnt, 4);
        r0 = n_rise; f0 = n_fall; bc0 = bit_cnt;
        scl_in = 1'b0; wclk(2); scl_in = 1'b1; wclk(10);
        chk("gl_no_fall", n_fall - f0, 0);
        chk("gl_no_rise", n_rise - r0, 0);
        chk("gl_bitcnt", bit_cnt, bc0);
        chk("gl_scl_f", scl_f, 1);
        scl_in = 1'b0; wclk(8);
        stop_cond();
        chk("gl_busy", busy, 0);

        // Repeated START mid data byte
        clr_logs();
        start_cond();
        send_byte(8'hA0);
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        chk("rs_bitcnt3", bit_cnt, 3);
        s0 = n_start;
        rstart_cond();
        chk("rs_start", n_start - s0, 1);
        chk("rs_bitcnt", bit_cnt, 0);
        chk("rs_first", first_byte, 1);
        chk("rs_busy", busy, 1);
        chk("rs_bv_n", n_bv, 1);
        chk("rs_rx", rx_byte, 8'hA0);
        stop_cond();

        // STOP after 5 bits, then SCL toggles in IDLE
        clr_logs();
        start_cond();
        send_byte(8'h12);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        chk("sp_bitcnt5", bit_cnt, 5);
        s0 = n_stop;
        stop_cond();
        chk("sp_stop", n_stop - s0, 1);
        chk("sp_busy", busy, 0);
        chk("sp_load", load, 0);
        chk("sp_bv_n", n_bv, 1);
        chk("sp_rx", rx_byte, 8'h12);
        for (int i = 0; i < 3; i++) begin
            scl_in = 1'b0; wclk(8);
            scl_in = 1'b1; wclk(8);
        end
        chk("sp_idle_bitcnt", bit_cnt, 0);
        chk("sp_idle_busy", busy, 0);

        // Reset during the address ACK
        clr_logs();
        start_cond();
        send_byte(8'hA1);
        sda_in = 1'b0; wclk(6); scl_in = 1'b1; wclk(4);
        chk("ra_load_pre", load, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ra_load_async", load, 0);
        chk("ra_busy_async", busy, 0);
        chk("ra_first_async", first_byte, 0);
        sda_in = 1'b1; scl_in = 1'b1;
        wclk(3);
        reset_n = 1'b1; wclk(10);
        chk("ra_busy", busy, 0);
        chk("ra_bitcnt", bit_cnt, 0);
        chk("ra_sda_f", sda_f, 1);

        // Recovery after reset
        clr_logs();
        start_cond();
        send_byte(8'h6D);
        send_bit(1'b0);
        stop_cond();
        chk("rec_bv_n", n_bv, 1);
        chk("rec_rx", rx_byte, 8'h6D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
